// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic {MD_MUL, MD_DIV} md_kind_t;

  // Quotient reported for any divide by zero
  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  // 32 restoring iterations plus one sign-fix cycle
  localparam int unsigned DIV_LAT = 33;

  // Decoder alu_op codes handled here (MIPS funct values)
  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  // Two's-complement negate when neg is set
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Magnitude of a 32-bit value, treated as signed only when is_signed is set
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return neg_if(v, is_signed && v[31]);
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle. The first iteration is
// taken on the start edge, so the result is valid in the cycle done is high.
module div_radix2 #(
  parameter int unsigned Iter = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned CntW = $clog2(Iter + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Iter);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            run_q, run_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dsr_q, dsr_d;

  logic [31:0] rem_in, quo_in, dsr_in, rem_nx, quo_nx;
  logic [32:0] rem_sh;
  logic        ge;

  // One restoring step, fed from the operands on start, else from the registers
  always_comb begin
    rem_in = start ? 32'd0 : rem_q;
    quo_in = start ? dividend : quo_q;
    dsr_in = start ? divisor : dsr_q;
    rem_sh = {rem_in, quo_in[31]};
    ge     = rem_sh >= {1'b0, dsr_in};
    // True difference is below 2^32 whenever ge holds, so 32-bit wrap is exact
    rem_nx = ge ? (rem_sh[31:0] - dsr_in) : rem_sh[31:0];
    quo_nx = {quo_in[30:0], ge};
  end

  // Iteration control and next-state selection
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    done  = run_q && (cnt_q == CntLast);
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = CntOne;
      rem_d = rem_nx;
      quo_d = quo_nx;
      dsr_d = divisor;
    end else if (run_q) begin
      if (done) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CntOne;
        rem_d = rem_nx;
        quo_d = quo_nx;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer owning architectural HI/LO.
// Optional feature macro: MULDIV_DIV0_FAST_EN (zero divisor completes in one cycle).
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [5:0]  alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  localparam int unsigned PDepth  = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam logic [5:0]  MulLast = 6'(MUL_LAT - 1);
  localparam logic [5:0]  DivLast = 6'(DIV_LAT - 1);
  localparam logic [5:0]  CntOne  = 6'd1;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dvd_q, dvd_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic [63:0] prod_q [PDepth];
  logic [63:0] prod_d [PDepth];

  md_kind_t    kind;
  logic        is_md, is_signed, start, mt_en, div0_now;
  logic [63:0] a_ext, b_ext, product, mul_res;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;

  // Decode the incoming op and form the 64-bit product of the extended operands
  always_comb begin
    is_md     = alu_op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    is_signed = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
    kind      = ((alu_op == ALU_MULT) || (alu_op == ALU_MULTU)) ? MD_MUL : MD_DIV;
    start     = op_valid && !flush && (state_q == IDLE) && is_md;
    mt_en     = op_valid && !flush && (state_q == IDLE);
    div0_now  = (src_b == 32'd0);
    // Low 64 bits of the extended product equal the signed/unsigned 64-bit result
    a_ext     = {{32{is_signed & src_a[31]}}, src_a};
    b_ext     = {{32{is_signed & src_b[31]}}, src_b};
    product   = a_ext * b_ext;
    div_start = start && (kind == MD_DIV);
  end

  assign busy      = (state_q == MUL) || (state_q == DIV);
  assign stall_req = start || (busy && !flush);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign mul_res   = prod_q[PDepth-1];

  div_radix2 #(
    .Iter(DIV_ITER)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (flush),
    .dividend (mag32(src_a, is_signed)),
    .divisor  (mag32(src_b, is_signed)),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Product pipeline: capture on a multiply start, then shift one stage per cycle
  always_comb begin
    prod_d[0] = (start && (kind == MD_MUL)) ? product : prod_q[0];
    for (int i = 1; i < PDepth; i++) begin
      prod_d[i] = prod_q[i-1];
    end
  end

  // Sequencer FSM, counter, sign fix and HI/LO write selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = CntOne;
          dvd_d     = src_a;
          neg_quo_d = is_signed && (src_a[31] ^ src_b[31]);
          neg_rem_d = is_signed && src_a[31];
          div0_d    = div0_now;
          if (kind == MD_MUL) begin
            if (MUL_LAT == 1) begin
              hi_d    = product[63:32];
              lo_d    = product[31:0];
              state_d = DONE;
            end else begin
              state_d = MUL;
            end
          end else begin
`ifdef MULDIV_DIV0_FAST_EN
            if (div0_now) begin
              hi_d    = src_a;
              lo_d    = DIV0_Q;
              state_d = DONE;
            end else begin
              state_d = DIV;
            end
`else
            state_d = DIV;
`endif
          end
        end else if (mt_en) begin
          if (alu_op == ALU_MTHI) hi_d = src_a;
          if (alu_op == ALU_MTLO) lo_d = src_a;
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == MulLast) begin
          hi_d    = mul_res[63:32];
          lo_d    = mul_res[31:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else if ((cnt_q == DivLast) && div_done) begin
          // A zero divisor bypasses the sign fix entirely
          if (div0_q) begin
            hi_d = dvd_q;
            lo_d = DIV0_Q;
          end else begin
            hi_d = neg_if(div_rem, neg_rem_q);
            lo_d = neg_if(div_quo, neg_quo_q);
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  // Product pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PDepth; i++) prod_q[i] <= '0;
    end else begin
      for (int i = 0; i < PDepth; i++) prod_q[i] <= prod_d[i];
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed table, hand-written corner
// sequences and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_seq;
  import muldiv_pkg::*;

  localparam int MulLat = 2;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int Div0Lat = 1;
`else
  localparam int Div0Lat = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, op_valid, flush;
  logic [5:0]  alu_op;
  logic [31:0] src_a, src_b;
  logic        stall_req, busy;
  logic [31:0] hi_o, lo_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cur_hi, cur_lo;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t       tbl [10];
  logic [5:0] ops [4];

  ex_muldiv_seq #(
    .MUL_LAT (MulLat),
    .DIV_ITER(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .alu_op   (alu_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall_req(stall_req),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      ps;
    logic [63:0] p;
    int          sa, sb;
    sa  = a;
    sb  = b;
    hi  = '0;
    lo  = '0;
    lat = 33;
    case (op)
      ALU_MULT: begin
        ps  = longint'(sa) * longint'(sb);
        p   = ps;
        hi  = p[63:32];
        lo  = p[31:0];
        lat = MulLat;
      end
      ALU_MULTU: begin
        p   = {32'd0, a} * {32'd0, b};
        hi  = p[63:32];
        lo  = p[31:0];
        lat = MulLat;
      end
      ALU_DIVU: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a; lat = Div0Lat;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      ALU_DIV: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a; lat = Div0Lat;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 32'd0;
        end else begin
          lo = sa / sb; hi = sa % sb;
        end
      end
      default: lat = 0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at the next negedge; returns in its DONE cycle with op still held
  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    int cnt;
    @(negedge clk);
    op_valid = 1'b1; alu_op = op; src_a = a; src_b = b;
    #1;
    check({name, "_start_stall"}, 32'(stall_req), 32'd1);
    cnt = 0;
    while (stall_req && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall_cycles"}, 32'(cnt), 32'(elat));
    check({name, "_busy_done"}, 32'(busy), 32'd0);
    check({name, "_hi"}, hi_o, ehi);
    check({name, "_lo"}, lo_o, elo);
    cur_hi = ehi;
    cur_lo = elo;
  endtask

  task automatic apply(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int elat);
    run_op(name, op, a, b, ehi, elo, elat);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ehi, elo;
    int          elat;
    logic [5:0]  rop;
    logic [31:0] ra, rb;

    tbl[0] = '{ALU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MulLat};
    tbl[1] = '{ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MulLat};
    tbl[2] = '{ALU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    tbl[3] = '{ALU_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         33};
    tbl[4] = '{ALU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, Div0Lat};
    tbl[5] = '{ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    tbl[6] = '{ALU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, Div0Lat};
    tbl[7] = '{ALU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    tbl[8] = '{ALU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         33};
    tbl[9] = '{ALU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         MulLat};
    ops[0] = ALU_MULT; ops[1] = ALU_MULTU; ops[2] = ALU_DIV; ops[3] = ALU_DIVU;

    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; alu_op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", 32'(stall_req), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);

    for (int i = 0; i < 10; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
            tbl[i].lat);
    end

    // MTHI / MTLO: no stall, visible the cycle after the write
    @(negedge clk);
    op_valid = 1'b1; alu_op = ALU_MTHI; src_a = 32'h0000_1234;
    #1;
    check("mthi_no_stall", 32'(stall_req), 32'd0);
    check("mthi_not_yet", hi_o, cur_hi);
    @(negedge clk);
    alu_op = ALU_MTLO; src_a = 32'h5555_0002;
    #1;
    check("mfhi_after_mthi", hi_o, 32'h0000_1234);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("mflo_after_mtlo", lo_o, 32'h5555_0002);
    cur_hi = 32'h0000_1234;
    cur_lo = 32'h5555_0002;

    // Flush mid-divide: abort next edge, stall drops immediately, HI/LO kept
    @(negedge clk);
    op_valid = 1'b1; alu_op = ALU_DIV; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall_drop", 32'(stall_req), 32'd0);
    check("flush_busy_before_edge", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flush_idle_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    check("flush_hi_kept", hi_o, cur_hi);
    check("flush_lo_kept", lo_o, cur_lo);

    // Flush in the start cycle blocks the start
    @(negedge clk);
    op_valid = 1'b1; alu_op = ALU_MULT; src_a = 32'd9; src_b = 32'd3; flush = 1'b1;
    #1;
    check("flush_start_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flush_start_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("flush_start_lo", lo_o, cur_lo);

    // Unknown op: no effect, no stall
    @(negedge clk);
    op_valid = 1'b1; alu_op = 6'h20; src_a = 32'hDEAD_BEEF; src_b = 32'd1;
    #1;
    check("unknown_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("unknown_busy", 32'(busy), 32'd0);
    check("unknown_hi", hi_o, cur_hi);
    check("unknown_lo", lo_o, cur_lo);

    // Back-to-back MULT: new op in DONE does not start; it starts in the IDLE cycle
    run_op("b2b_first", ALU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, MulLat);
    src_a = 32'hFFFF_FFFB; src_b = 32'd6;
    #1;
    check("b2b_done_no_start", 32'(stall_req), 32'd0);
    apply("b2b_second", ALU_MULT, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFE2, MulLat);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(3)];
      ra  = pick();
      rb  = pick();
      model(rop, ra, rb, ehi, elo, elat);
      apply($sformatf("rand%0d_op%02h_%08h_%08h", i, rop, ra, rb), rop, ra, rb, ehi, elo, elat);
    end

    // Reset mid-operation discards the partial result and clears HI/LO
    @(negedge clk);
    op_valid = 1'b1; alu_op = ALU_DIVU; src_a = 32'd50; src_b = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    repeat (40) @(negedge clk);
    #1;
    check("midrst_lo_later", lo_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
